// File: rtl/phase_sequencer.sv
// Phase sequencer: generates the 3-bit execution phase, latches the instruction register
// and holds the S/Z/C/V flags. Define PHASE_SEQ_ICOUNT_EN to build the retired-instruction counter.
module phase_sequencer #(
  parameter int unsigned IR_WIDTH     = 16,
  parameter int unsigned ICOUNT_WIDTH = 32,
  parameter logic [2:0]  FLAG_PHASE   = 3'b011
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    step,
  input  logic                    hlt,
  input  logic [IR_WIDTH-1:0]     mem_rdata,
  input  logic [3:0]              alu_flags,
  input  logic                    flag_we,
  output logic [2:0]              phase,
  output logic [IR_WIDTH-1:0]     ir,
  output logic                    S,
  output logic                    Z,
  output logic                    C,
  output logic                    V,
  output logic                    pc_update,
  output logic                    running,
  output logic                    halted,
  output logic [ICOUNT_WIDTH-1:0] icount
);

  typedef enum logic [1:0] {StIdle, StRun, StStep, StHalt} state_e;

  state_e                state_q, state_d;
  logic [2:0]            phase_q, phase_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  start_q, stop_q, step_q;
  logic [IR_WIDTH-1:0]   ir_q;
  logic [3:0]            flags_q;

  logic start_edge, stop_edge, step_edge;
  logic hlt_valid, retire;

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop & ~stop_q;
  assign step_edge  = step & ~step_q;

  // Decoder hlt is only meaningful once the instruction has been latched.
  assign hlt_valid = hlt && (phase_q >= 3'd2) && (phase_q <= 3'd5);
  assign retire    = (phase_q == 3'd5) && (state_q == StRun || state_q == StStep) && !hlt;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    stop_pend_d = stop_pend_q;
    unique case (state_q)
      StIdle: begin
        phase_d     = 3'd0;
        stop_pend_d = 1'b0;
        if (start_edge) begin
          state_d = StRun;
          phase_d = 3'd1;
        end else if (step_edge) begin
          state_d = StStep;
          phase_d = 3'd1;
        end
      end
      StRun: begin
        if (stop_edge) stop_pend_d = 1'b1;
        if (hlt_valid) begin
          state_d     = StHalt;
          phase_d     = 3'd0;
          stop_pend_d = 1'b0;
        end else if (phase_q == 3'd5) begin
          if (stop_pend_q) begin
            state_d     = StIdle;
            phase_d     = 3'd0;
            stop_pend_d = 1'b0;
          end else begin
            phase_d = 3'd1;
          end
        end else if (phase_q >= 3'd1 && phase_q <= 3'd4) begin
          phase_d = phase_q + 3'd1;
        end else begin
          state_d     = StIdle;
          phase_d     = 3'd0;
          stop_pend_d = 1'b0;
        end
      end
      StStep: begin
        if (hlt_valid) begin
          state_d = StHalt;
          phase_d = 3'd0;
        end else if (phase_q >= 3'd1 && phase_q <= 3'd4) begin
          phase_d = phase_q + 3'd1;
        end else begin
          state_d = StIdle;
          phase_d = 3'd0;
        end
      end
      StHalt: begin
        phase_d     = 3'd0;
        stop_pend_d = 1'b0;
      end
      default: begin
        state_d     = StIdle;
        phase_d     = 3'd0;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      phase_q     <= 3'd0;
      stop_pend_q <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      step_q      <= 1'b0;
      ir_q        <= '0;
      flags_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      stop_pend_q <= stop_pend_d;
      start_q     <= start;
      stop_q      <= stop;
      step_q      <= step;
      if (phase_q == 3'd1) ir_q <= mem_rdata;
      if (phase_q == FLAG_PHASE && flag_we) flags_q <= alu_flags;
    end
  end

`ifdef PHASE_SEQ_ICOUNT_EN
  logic [ICOUNT_WIDTH-1:0] icount_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      icount_q <= '0;
    end else if (retire) begin
      icount_q <= icount_q + 1'b1;
    end
  end

  assign icount = icount_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign icount        = '0;
`endif

  assign phase     = phase_q;
  assign ir        = ir_q;
  assign S         = flags_q[3];
  assign Z         = flags_q[2];
  assign C         = flags_q[1];
  assign V         = flags_q[0];
  assign pc_update = (phase_q == 3'd5);
  assign running   = (state_q == StRun);
  assign halted    = (state_q == StHalt);

endmodule
